// File: rtl/serv_mem_pkg.sv
// Shared definitions for the bit-serial load/store sequencer.
package serv_mem_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BUS   = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam int WORD_BITS = 32;

  // Width of the shift counter: one word takes WORD_BITS/w serial cycles.
  function automatic int cnt_w(input int w);
    return $clog2(WORD_BITS / w);
  endfunction

endpackage

// File: rtl/serv_mem_ctrl_if.sv
// Request, Wishbone data-bus and status signals between the core and the
// load/store sequencer.
interface serv_mem_ctrl_if;
  logic       i_req;
  logic       i_we;
  logic       i_word;
  logic       i_half;
  logic [1:0] i_adr_lsb;
  logic       i_misalign;
  logic       i_wb_ack;
  logic [1:0] o_lsb;
  logic [1:0] o_bytecnt;
  logic       o_shift_en;
  logic       o_wb_cyc;
  logic       o_wb_we;
  logic       o_busy;
  logic       o_done;
  logic       o_trap;

  // Core / memory-interface side: issues requests, observes sequencing.
  modport master (
    output i_req, i_we, i_word, i_half, i_adr_lsb, i_misalign, i_wb_ack,
    input  o_lsb, o_bytecnt, o_shift_en, o_wb_cyc, o_wb_we, o_busy,
           o_done, o_trap
  );

  // Sequencer side.
  modport slave (
    input  i_req, i_we, i_word, i_half, i_adr_lsb, i_misalign, i_wb_ack,
    output o_lsb, o_bytecnt, o_shift_en, o_wb_cyc, o_wb_we, o_busy,
           o_done, o_trap
  );
endinterface

// File: rtl/serv_mem_cnt.sv
// Serial shift counter: up-counter with enable, synchronous clear and a
// terminal-count flag. Wraps naturally to zero after the last count.
module serv_mem_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // Count shift cycles; clear on reset or when a new request is accepted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/serv_mem_ctrl.sv
// Load/store sequencer for the bit-serial memory path.
//
//   state | meaning
//   IDLE  | waiting for i_req; latches access control on acceptance
//   CHECK | one cycle to evaluate misalignment; trap or pick first phase
//   BUS   | Wishbone cycle held until i_wb_ack
//   SHIFT | serial data shift for one full word (32/W cycles)
//
// Store = SHIFT then BUS (data must be in place before the write).
// Load  = BUS then SHIFT (read data is shifted out after the ack).
module serv_mem_ctrl
  import serv_mem_pkg::*;
#(
  parameter int W        = 1,
  parameter int WITH_CSR = 1
) (
  input logic          i_clk,
  input logic          i_rst,
  serv_mem_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(W);

  state_t             state;
  state_t             state_nxt;
  logic               we_q;
  logic               word_q;
  logic               half_q;
  logic [1:0]         lsb_q;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               shift_en;
  logic               wb_cyc;
  logic               busy;
  logic               done;
  logic               trap;

  // A request is only seen in IDLE; anything arriving while busy is dropped.
  assign accept = (state == IDLE) && bus.i_req;

  serv_mem_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (accept),
    .en   (shift_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch access control when a request is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q   <= 1'b0;
      word_q <= 1'b0;
      half_q <= 1'b0;
      lsb_q  <= 2'b00;
    end else if (accept) begin
      we_q   <= bus.i_we;
      word_q <= bus.i_word;
      half_q <= bus.i_half;
      lsb_q  <= bus.i_adr_lsb;
    end
  end

  // Next state and state-decoded outputs. cyc/shift_en depend on state only;
  // done/trap also qualify on the ack/misalign of the terminating cycle.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    wb_cyc    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if ((WITH_CSR != 0) && bus.i_misalign) begin
          trap      = 1'b1;
          state_nxt = IDLE;
        end else if (we_q) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        busy   = 1'b1;
        wb_cyc = 1'b1;
        if (bus.i_wb_ack) begin
          if (we_q) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_last) begin
          if (we_q) begin
            state_nxt = BUS;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.o_lsb      = lsb_q;
  assign bus.o_bytecnt  = cnt[CNT_W-1 -: 2];
  assign bus.o_shift_en = shift_en;
  assign bus.o_wb_cyc   = wb_cyc;
  assign bus.o_wb_we    = we_q & wb_cyc;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_trap     = trap;

endmodule

// File: tb/tb_serv_mem_ctrl.sv
// Bench for serv_mem_ctrl: four instances (W=1/CSR, W=1/no CSR, W=4, W=8).
// Expected per-cycle outputs are built from transaction-level rules
// (phase lengths, byte index = shift_index*W/8) into a vector queue.
module tb_serv_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] tag;
    logic       chk;
    logic       rst;
    logic       req;
    logic       we;
    logic       word;
    logic       half;
    logic [1:0] lsb;
    logic       mis;
    logic       ack;
    logic [9:0] exp;   // {lsb, bytecnt, shift_en, cyc, we, busy, done, trap}
  } vec_t;

  logic [3:0]      rst_v  = 4'hF;
  logic [3:0]      req_v  = '0;
  logic [3:0]      we_v   = '0;
  logic [3:0]      word_v = '0;
  logic [3:0]      half_v = '0;
  logic [3:0]      mis_v  = '0;
  logic [3:0]      ack_v  = '0;
  logic [3:0][1:0] lsb_v  = '0;
  logic [3:0][9:0] out_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serv_mem_ctrl_if bif();
    serv_mem_ctrl #(
      .W        ((g == 2) ? 4 : ((g == 3) ? 8 : 1)),
      .WITH_CSR ((g == 1) ? 0 : 1)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst_v[g]),
      .bus   (bif)
    );
    assign bif.i_req      = req_v[g];
    assign bif.i_we       = we_v[g];
    assign bif.i_word     = word_v[g];
    assign bif.i_half     = half_v[g];
    assign bif.i_adr_lsb  = lsb_v[g];
    assign bif.i_misalign = mis_v[g];
    assign bif.i_wb_ack   = ack_v[g];
    assign out_v[g] = {bif.o_lsb, bif.o_bytecnt, bif.o_shift_en, bif.o_wb_cyc,
                       bif.o_wb_we, bif.o_busy, bif.o_done, bif.o_trap};
  end

  vec_t q[$];
  int   lsb_m [4];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic int w_of(int d);
    return (d == 2) ? 4 : ((d == 3) ? 8 : 1);
  endfunction

  function automatic bit csr_of(int d);
    return d != 1;
  endfunction

  function automatic logic [9:0] ex(int l, int bc, bit sh, bit cyc, bit we,
                                    bit busy, bit done, bit trap);
    return {2'(l), 2'(bc), sh, cyc, we, busy, done, trap};
  endfunction

  function automatic bit rb(bit noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Quiet idle-state vector for DUT d.
  function automatic vec_t base(int d, int tag);
    vec_t v;
    v = '0;
    v.dut = 2'(d);
    v.tag = 8'(tag);
    v.chk = 1'b1;
    v.exp = ex(lsb_m[d], 0, 0, 0, 0, 0, 0, 0);
    return v;
  endfunction

  function automatic vec_t mk(int d, bit req, bit we, bit word, bit half,
                              int lsb, bit mis, bit ack, logic [9:0] e);
    vec_t v;
    v = base(d, 0);
    v.req = req; v.we = we; v.word = word; v.half = half;
    v.lsb = 2'(lsb); v.mis = mis; v.ack = ack; v.exp = e;
    return v;
  endfunction

  // Busy-cycle vector with optional noise: requests, stray ack/misalign.
  function automatic vec_t noisy(int d, int tag, bit noise);
    vec_t v;
    v = base(d, tag);
    v.req  = rb(noise);
    v.we   = rb(noise);
    v.word = rb(noise);
    v.half = rb(noise);
    v.lsb  = noise ? 2'($urandom_range(0, 3)) : 2'b00;
    v.mis  = rb(noise);
    v.ack  = rb(noise);
    return v;
  endfunction

  task automatic push_idle(int d, int tag, bit noise, int cnt);
    vec_t v;
    for (int i = 0; i < cnt; i++) begin
      v = base(d, tag);
      v.ack = rb(noise);
      v.mis = rb(noise);
      q.push_back(v);
    end
  endtask

  task automatic push_rst(int d, int tag);
    vec_t v;
    v = base(d, tag);
    v.rst = 1'b1;
    v.chk = 1'b0;
    q.push_back(v);
    lsb_m[d] = 0;
  endtask

  task automatic push_shift(int d, int tag, bit noise, bit fin);
    vec_t v;
    int   n;
    n = 32 / w_of(d);
    for (int i = 0; i < n; i++) begin
      v = noisy(d, tag, noise);
      v.exp = ex(lsb_m[d], i * w_of(d) / 8, 1, 0, 0, 1, fin && (i == n - 1), 0);
      q.push_back(v);
    end
  endtask

  task automatic push_bus(int d, int tag, bit noise, int waits, bit we, bit fin);
    vec_t v;
    for (int j = 0; j <= waits; j++) begin
      v = noisy(d, tag, noise);
      v.ack = (j == waits);
      v.exp = ex(lsb_m[d], 0, 0, 1, we, 1, fin && (j == waits), 0);
      q.push_back(v);
    end
  endtask

  // One complete transaction as a sequence of cycle vectors.
  task automatic gen(int d, bit we, bit word, bit half, int lsb, bit mis,
                     int waits, bit noise, int tag);
    vec_t v;
    bit   trp;
    v = base(d, tag);
    v.req = 1'b1; v.we = we; v.word = word; v.half = half; v.lsb = 2'(lsb);
    v.ack = rb(noise); v.mis = rb(noise);
    q.push_back(v);
    lsb_m[d] = lsb;
    trp = csr_of(d) && mis;
    v = noisy(d, tag, noise);
    v.mis = mis;
    v.exp = ex(lsb, 0, 0, 0, 0, 1, 0, trp);
    q.push_back(v);
    if (!trp) begin
      if (we) begin
        push_shift(d, tag, noise, 1'b0);
        push_bus(d, tag, noise, waits, 1'b1, 1'b1);
      end else begin
        push_bus(d, tag, noise, waits, 1'b0, 1'b0);
        push_shift(d, tag, noise, 1'b1);
      end
    end
  endtask

  // Transaction cut short by reset asserted in its k-th cycle.
  task automatic gen_rst_at(int d, bit we, int lsb, int waits, int k, int tag);
    int base_sz;
    base_sz = q.size();
    gen(d, we, 1'b1, 1'b0, lsb, 1'b0, waits, 1'b0, tag);
    while (q.size() > base_sz + k) void'(q.pop_back());
    push_rst(d, tag);
    push_idle(d, tag, 1'b0, 1);
  endtask

  task automatic drive(vec_t v);
    rst_v = '0; req_v = '0; we_v = '0; word_v = '0; half_v = '0;
    mis_v = '0; ack_v = '0; lsb_v = '0;
    rst_v[v.dut]  = v.rst;
    req_v[v.dut]  = v.req;
    we_v[v.dut]   = v.we;
    word_v[v.dut] = v.word;
    half_v[v.dut] = v.half;
    lsb_v[v.dut]  = v.lsb;
    mis_v[v.dut]  = v.mis;
    ack_v[v.dut]  = v.ack;
  endtask

  task automatic apply();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      drive(q[i]);
      #1;
      if (q[i].chk) begin
        n_assert++;
        if (out_v[q[i].dut] !== q[i].exp) begin
          n_fail++;
          $display("FAIL cycle_outputs tag=%0d vec=%0d dut=%0d {lsb,bytecnt,sh,cyc,we,busy,done,trap} got %b expected %b",
                   q[i].tag, i, q[i].dut, out_v[q[i].dut], q[i].exp);
        end
      end
    end
    q.delete();
  endtask

  vec_t tbl [4];

  initial begin
    for (int d = 0; d < 4; d++) lsb_m[d] = 0;

    // Reset each instance, then confirm the all-zero idle state.
    for (int d = 0; d < 4; d++) push_rst(d, 1);
    for (int d = 0; d < 4; d++) push_idle(d, 1, 1'b0, 1);
    apply();

    // Literal table: stray ack/misalign in IDLE, then a trapped word load.
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[1] = mk(0, 1, 0, 1, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 1, 0, 1));
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(tbl[i]);
    lsb_m[0] = 1;
    apply();

    // Load word, 3 wait states, then store half at lsb=2.
    gen(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3, 1'b0, 10);
    push_idle(0, 10, 1'b0, 1);
    gen(0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 1'b0, 11);
    push_idle(0, 11, 1'b0, 1);
    // Misaligned load: trap with CSR, normal completion without.
    gen(0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 1'b0, 12);
    push_idle(0, 12, 1'b0, 1);
    gen(1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 1'b0, 13);
    push_idle(1, 13, 1'b0, 1);
    // Requests and stray acks while busy are ignored.
    gen(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 2, 1'b1, 14);
    gen(0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 2, 1'b1, 15);
    push_idle(0, 15, 1'b0, 1);
    // Reset during BUS (cyc high) and during SHIFT at cnt=17.
    gen_rst_at(0, 1'b0, 3, 3, 3, 16);
    gen_rst_at(0, 1'b0, 2, 0, 20, 17);
    gen(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 18);
    push_idle(0, 18, 1'b0, 1);
    // W=4 byte load back-to-back with a second load; W=8 store.
    gen(2, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 1'b0, 19);
    gen(2, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 20);
    push_idle(2, 20, 1'b0, 1);
    gen(3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 21);
    push_idle(3, 21, 1'b0, 1);
    apply();

    // Randomised transactions across all instances.
    for (int it = 0; it < 150; it++) begin
      int d;
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        gen_rst_at(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 30), 100);
      end else begin
        gen(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5),
            1'($urandom_range(0, 1)), 101);
        push_idle(d, 101, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end
      apply();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
